uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_tick.sv | 31 +++
 rtl/uart_rx.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: oversample ratio, data width and the receiver FSM state encoding.
// Used by uart_rx and uart_baud_tick, and intended for reuse by the matching transmitter.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_START     = 3'd1;
  localparam state_t S_DATA      = 3'd2;
  localparam state_t S_PARITY    = 3'd3;
  localparam state_t S_STOP      = 3'd4;
  localparam state_t S_WAIT_IDLE = 3'd5;

  // Even parity bit for a data byte: XOR of all data bits.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running 16x oversample tick: one-cycle pulse every CLK_FREQ/(BAUD*16) clocks.
// Shared between the UART receiver and transmitter.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic clk,
  input  logic reset,
  output logic o_tick
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  // A divisor below 1 degenerates to a tick on every clock.
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign o_tick = (cnt_q == DIV_M1);
  assign cnt_d  = o_tick ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1 frames
// with an even-parity check. dbg_state_o exposes the FSM state.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rxd,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_busy,
  output state_t     dbg_state_o
);

  localparam logic [3:0] TICK_HALF = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

  logic                 tick;
  logic [1:0]           sync_q;
  logic                 rxd_s;
  state_t               state_q, state_d;
  logic [3:0]           tick_cnt_q, tick_cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_done_q, rx_done_d;
  logic                 frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_err_q, par_err_d;
`endif

  uart_baud_tick #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .o_tick (tick)
  );

  assign rxd_s       = sync_q[1];
  assign rx_data     = rx_data_q;
  assign rx_done     = rx_done_q;
  assign frame_err   = frame_err_q;
  assign rx_busy     = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d   = par_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rxd_s) begin
          state_d    = S_START;
          tick_cnt_d = '0;
        end
      end
      S_START: begin
        // Re-check the line at mid start bit; a high level means it was a glitch.
        if (tick) begin
          if (tick_cnt_q == TICK_HALF) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = rxd_s ? S_IDLE : S_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            shift_d    = {rxd_s, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            par_err_d  = rxd_s ^ even_parity(shift_q);
            state_d    = S_STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            if (rxd_s && !par_err_q) begin
`else
            if (rxd_s) begin
`endif
              rx_data_d = shift_q;
              rx_done_d = 1'b1;
              state_d   = S_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = S_WAIT_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      S_WAIT_IDLE: begin
        // Hold off through a break until the line returns to idle.
        if (rxd_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q      <= 2'b11;
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      sync_q      <= {sync_q[0], i_rxd};
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= par_err_d;
`endif
    end
  end

endmodule
